mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one memory bus between two requesters: the fetch stage (I side) and the memory stage (D side, built from mem_read_req/mem_write_req).
- Fixed D-over-I priority, with a starvation guard for I. Each grant is held for a whole burst.
- Routes bus responses back to the granted requester only.
- Sits between the pipeline's memory interfaces and the single cache/AXI bridge port.

Parameters:
- MAX_WAIT, 4, consecutive D grants that may go to D while I is pending; after that, I must be granted next.
- LEN_W, 4, width of burst length field (beats-1).

Ports:
- clk  input  1  clock
- resetn  input  1  reset; synchronous, active-low
- ireq_valid  input  1  I request valid
- ireq_addr  input  32  I address
- ireq_size  input  3  I access size
- ireq_len  input  LEN_W  I beats-1
- ireq_is_write  input  1  I write flag (normally 0)
- ireq_strobe  input  4  I byte strobe
- ireq_data  input  32  I write data
- dreq_valid, dreq_addr, dreq_size, dreq_len, dreq_is_write, dreq_strobe, dreq_data  input  same widths  D request, same meanings
- iresp_ready  output  1  I response beat valid
- iresp_last  output  1  I final beat
- iresp_data  output  32  I read data
- dresp_ready, dresp_last, dresp_data  output  1/1/32  D response
- creq_valid  output  1  bus request valid
- creq_addr, creq_size, creq_len, creq_is_write, creq_strobe, creq_data  output  32/3/LEN_W/1/4/32  bus request fields
- cresp_ready  input  1  bus beat valid
- cresp_last  input  1  bus final beat
- cresp_data  input  32  bus read data
- busy  output  1  state != IDLE
- proto_err  output  1  sticky burst-length mismatch flag

Behaviour:
- States: IDLE, BUSY. Registers: state, sel (0=I, 1=D), beat counter cnt[LEN_W-1:0], starvation counter wait_cnt[$clog2(MAX_WAIT+1)-1:0], proto_err.
- Reset (resetn=0 at clk edge): state=IDLE, sel=0, cnt=0, wait_cnt=0, proto_err=0. All outputs 0 in the following cycle. This includes reset mid-burst: the burst is abandoned and no further beats are forwarded.
- IDLE grant decision (registered; bus sees the request 1 cycle after the arbiter accepts it):
  - both valid, wait_cnt<MAX_WAIT: grant D, wait_cnt++.
  - both valid, wait_cnt==MAX_WAIT: grant I, wait_cnt=0.
  - only D valid: grant D; wait_cnt unchanged.
  - only I valid: grant I, wait_cnt=0.
  - neither valid: stay IDLE.
  - On any grant: state=BUSY, cnt=0.
- BUSY:
  - creq_valid=1; creq_* fields are the combinational copy of the selected requester's fields.
  - The requester must hold its request stable until its last beat. Violations are not checked.
  - Each cresp_ready: cnt++ (wraps modulo 2^LEN_W).
  - cresp_ready & cresp_last: state=IDLE. A new grant can occur the following cycle (1 idle cycle minimum between bursts).
- IDLE outputs: creq_valid=0, creq_* fields=0.
- Response routing:
  - xresp_data = cresp_data for both sides (broadcast).
  - iresp_ready = BUSY & sel==0 & cresp_ready; dresp_ready = BUSY & sel==1 & cresp_ready. The _last outputs are gated identically.
  - cresp_ready in IDLE is ignored and causes no error.
- proto_err is set, and stays set until reset, when either:
  - cresp_ready & cresp_last with cnt != selected len, or
  - cresp_ready & !cresp_last with cnt == selected len.
  - The burst still terminates only on cresp_last.
- busy = (state==BUSY).
- A requester deasserting valid while granted does not abort the burst.
- Simultaneous last beat and new requests: the new requests are only arbitrated in the next IDLE cycle.

Test Plan:
- Single D read, dreq_len=0, addr=0x1000: creq_valid rises 1 cycle after dreq_valid; cresp_ready=cresp_last=1 with data 0xDEADBEEF → dresp_ready=dresp_last=1 with dresp_data=0xDEADBEEF; iresp_ready stays 0; busy returns 0.
- I and D both valid continuously, all bursts single-beat, MAX_WAIT=4 → grant sequence D,D,D,D,I,D,D,D,D,I…; creq_addr alternates accordingly.
- I burst, ireq_len=3, bus returns 4 beats with last on beat 4 → iresp_ready pulses 4 times, iresp_last on the 4th; proto_err=0.
- D burst, len=3, but bus asserts last on beat 2 → burst ends after 2 beats; proto_err=1 and stays set through subsequent clean transfers.
- Reset asserted after 2 of 4 beats → next cycle creq_valid=0, busy=0, proto_err=0. Remaining cresp_ready pulses produce no iresp/dresp activity. A new request is granted normally after resetn=1.
- D write: dreq_is_write=1, strobe=0x3, data=0x0000ABCD, addr=0x2002 → creq fields match exactly while BUSY; all fields return to 0 after last.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares a single memory bus port between the fetch stage (I side) and the
// memory stage (D side). D has fixed priority over I, but after MAX_WAIT
// consecutive contested D grants, I is granted next so it cannot starve.
// A grant is held for a whole burst, and bus response beats are routed
// only to the requester that owns the current burst.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   ireq_*               I-side request (valid, addr, size, len, is_write,
//                        strobe, data)
//   dreq_*               D-side request, same fields as I side
//   iresp_*, dresp_*     per-side response (ready, last, data)
//   creq_*               request presented to the bus (zero while idle)
//   cresp_*              bus response (ready, last, data)
//   busy                 a burst is in progress
//   proto_err            sticky flag: bus last-beat disagreed with burst len
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int LEN_W    = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ireq_valid,
  input  logic [31:0]      ireq_addr,
  input  logic [2:0]       ireq_size,
  input  logic [LEN_W-1:0] ireq_len,
  input  logic             ireq_is_write,
  input  logic [3:0]       ireq_strobe,
  input  logic [31:0]      ireq_data,
  input  logic             dreq_valid,
  input  logic [31:0]      dreq_addr,
  input  logic [2:0]       dreq_size,
  input  logic [LEN_W-1:0] dreq_len,
  input  logic             dreq_is_write,
  input  logic [3:0]       dreq_strobe,
  input  logic [31:0]      dreq_data,
  output logic             iresp_ready,
  output logic             iresp_last,
  output logic [31:0]      iresp_data,
  output logic             dresp_ready,
  output logic             dresp_last,
  output logic [31:0]      dresp_data,
  output logic             creq_valid,
  output logic [31:0]      creq_addr,
  output logic [2:0]       creq_size,
  output logic [LEN_W-1:0] creq_len,
  output logic             creq_is_write,
  output logic [3:0]       creq_strobe,
  output logic [31:0]      creq_data,
  input  logic             cresp_ready,
  input  logic             cresp_last,
  input  logic [31:0]      cresp_data,
  output logic             busy,
  output logic             proto_err
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;          // 0 = I side, 1 = D side
  logic [LEN_W-1:0]  cnt_q, cnt_d;          // beats seen in current burst
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              proto_err_q, proto_err_d;

  logic [LEN_W-1:0]  sel_len;
  logic              in_busy;

  assign in_busy = (state_q == BUSY);
  // The owner holds its request stable for the whole burst, so the live
  // len input is the burst length.
  assign sel_len = sel_q ? dreq_len : ireq_len;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      wait_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    wait_cnt_d  = wait_cnt_q;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if (dreq_valid && ireq_valid) begin
          // Contested: D wins until I has been passed over MAX_WAIT times.
          if (wait_cnt_q < MAX_WAIT_C) begin
            sel_d      = 1'b1;
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end else begin
            sel_d      = 1'b0;
            wait_cnt_d = '0;
          end
          state_d = BUSY;
          cnt_d   = '0;
        end else if (dreq_valid) begin
          // Uncontested D grant does not count against I.
          sel_d   = 1'b1;
          state_d = BUSY;
          cnt_d   = '0;
        end else if (ireq_valid) begin
          sel_d      = 1'b0;
          wait_cnt_d = '0;
          state_d    = BUSY;
          cnt_d      = '0;
        end
      end
      BUSY: begin
        if (cresp_ready) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cresp_last) begin
            if (cnt_q != sel_len) proto_err_d = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == sel_len) begin
            // Beat count reached len but the bus did not end the burst;
            // keep going until the bus says last.
            proto_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    creq_valid    = 1'b0;
    creq_addr     = '0;
    creq_size     = '0;
    creq_len      = '0;
    creq_is_write = 1'b0;
    creq_strobe   = '0;
    creq_data     = '0;
    if (in_busy) begin
      creq_valid    = 1'b1;
      creq_addr     = sel_q ? dreq_addr     : ireq_addr;
      creq_size     = sel_q ? dreq_size     : ireq_size;
      creq_len      = sel_q ? dreq_len      : ireq_len;
      creq_is_write = sel_q ? dreq_is_write : ireq_is_write;
      creq_strobe   = sel_q ? dreq_strobe   : ireq_strobe;
      creq_data     = sel_q ? dreq_data     : ireq_data;
    end
  end

  assign iresp_ready = in_busy && !sel_q && cresp_ready;
  assign iresp_last  = in_busy && !sel_q && cresp_ready && cresp_last;
  assign dresp_ready = in_busy &&  sel_q && cresp_ready;
  assign dresp_last  = in_busy &&  sel_q && cresp_ready && cresp_last;
  assign iresp_data  = cresp_data;
  assign dresp_data  = cresp_data;
  assign busy        = in_busy;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed scenarios with literal expectations, followed by randomized
// traffic. A transaction-level model (who owns the bus, how many beats have
// been seen, how many times I has been passed over) predicts every output,
// and a negedge process compares the DUT against it each cycle.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int LEN_W    = 4;

  logic clk = 1'b0;
  logic resetn;
  logic ireq_valid, ireq_is_write, dreq_valid, dreq_is_write;
  logic [31:0] ireq_addr, ireq_data, dreq_addr, dreq_data;
  logic [2:0]  ireq_size, dreq_size;
  logic [LEN_W-1:0] ireq_len, dreq_len;
  logic [3:0]  ireq_strobe, dreq_strobe;
  logic iresp_ready, iresp_last, dresp_ready, dresp_last;
  logic [31:0] iresp_data, dresp_data;
  logic creq_valid, creq_is_write;
  logic [31:0] creq_addr, creq_data;
  logic [2:0]  creq_size;
  logic [LEN_W-1:0] creq_len;
  logic [3:0]  creq_strobe;
  logic cresp_ready, cresp_last;
  logic [31:0] cresp_data;
  logic busy, proto_err;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_WAIT(MAX_WAIT), .LEN_W(LEN_W)) dut (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_size(ireq_size),
    .ireq_len(ireq_len), .ireq_is_write(ireq_is_write),
    .ireq_strobe(ireq_strobe), .ireq_data(ireq_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_len(dreq_len), .dreq_is_write(dreq_is_write),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .iresp_ready(iresp_ready), .iresp_last(iresp_last), .iresp_data(iresp_data),
    .dresp_ready(dresp_ready), .dresp_last(dresp_last), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_addr(creq_addr), .creq_size(creq_size),
    .creq_len(creq_len), .creq_is_write(creq_is_write),
    .creq_strobe(creq_strobe), .creq_data(creq_data),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data),
    .busy(busy), .proto_err(proto_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: who holds the bus; beats: beats delivered in this burst;
  // passed_over: contested grants I has lost since its last grant.
  bit m_busy = 0;
  bit m_side = 0;         // 0 = I, 1 = D
  int m_beats = 0;
  int m_passed = 0;
  bit m_err = 0;

  always @(posedge clk) begin
    automatic bit nb = m_busy, ns = m_side, ne = m_err;
    automatic int nbe = m_beats, np = m_passed;
    automatic int len;
    if (!resetn) begin
      nb = 0; ns = 0; nbe = 0; np = 0; ne = 0;
    end else if (!m_busy) begin
      if (ireq_valid || dreq_valid) begin
        nb = 1; nbe = 0;
        if (ireq_valid && dreq_valid) begin
          if (m_passed < MAX_WAIT) begin ns = 1; np = m_passed + 1; end
          else begin ns = 0; np = 0; end
        end else if (dreq_valid) ns = 1;
        else begin ns = 0; np = 0; end
      end
    end else if (cresp_ready) begin
      len = m_side ? int'(dreq_len) : int'(ireq_len);
      if (cresp_last) begin
        if (m_beats != len) ne = 1;
        nb = 0;
      end else if (m_beats == len) ne = 1;
      nbe = (m_beats + 1) % (1 << LEN_W);
    end
    m_busy <= nb; m_side <= ns; m_beats <= nbe; m_passed <= np; m_err <= ne;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      automatic bit on_i = m_busy && !m_side;
      automatic bit on_d = m_busy && m_side;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("proto_err", 32'(proto_err), 32'(m_err));
      chk("creq_valid", 32'(creq_valid), 32'(m_busy));
      chk("creq_addr", creq_addr, on_d ? dreq_addr : on_i ? ireq_addr : 32'h0);
      chk("creq_size", 32'(creq_size), 32'(on_d ? dreq_size : on_i ? ireq_size : 3'h0));
      chk("creq_len", 32'(creq_len), 32'(on_d ? dreq_len : on_i ? ireq_len : 4'h0));
      chk("creq_is_write", 32'(creq_is_write),
          32'(on_d ? dreq_is_write : on_i ? ireq_is_write : 1'b0));
      chk("creq_strobe", 32'(creq_strobe),
          32'(on_d ? dreq_strobe : on_i ? ireq_strobe : 4'h0));
      chk("creq_data", creq_data, on_d ? dreq_data : on_i ? ireq_data : 32'h0);
      chk("iresp_ready", 32'(iresp_ready), 32'(on_i && cresp_ready));
      chk("iresp_last", 32'(iresp_last), 32'(on_i && cresp_ready && cresp_last));
      chk("dresp_ready", 32'(dresp_ready), 32'(on_d && cresp_ready));
      chk("dresp_last", 32'(dresp_last), 32'(on_d && cresp_ready && cresp_last));
      chk("iresp_data", iresp_data, cresp_data);
      chk("dresp_data", dresp_data, cresp_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit last, input logic [31:0] data);
    cresp_ready = 1'b1; cresp_last = last; cresp_data = data;
  endtask

  task automatic no_beat();
    cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = '0;
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 20) begin cyc(); n++; end
    if (!busy) begin
      checks++; failures++;
      $display("FAIL %s grant timeout got=0 want=1", name);
    end
  endtask

  initial begin
    resetn = 1'b0;
    ireq_valid = 0; ireq_addr = 0; ireq_size = 0; ireq_len = 0;
    ireq_is_write = 0; ireq_strobe = 0; ireq_data = 0;
    dreq_valid = 0; dreq_addr = 0; dreq_size = 0; dreq_len = 0;
    dreq_is_write = 0; dreq_strobe = 0; dreq_data = 0;
    no_beat();
    cyc();
    cmp_en = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_creq_valid", 32'(creq_valid), 32'h0);
    #1;
    resetn = 1'b1;
    cyc();

    // 1: single D read
    dreq_valid = 1; dreq_addr = 32'h1000; dreq_len = 0; dreq_size = 3'd2;
    @(negedge clk);
    chk("t1_not_yet", 32'(creq_valid), 32'h0);
    cyc();
    dreq_valid = 0;
    beat(1'b1, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_creq_valid", 32'(creq_valid), 32'h1);
    chk("t1_creq_addr", creq_addr, 32'h1000);
    chk("t1_dresp_ready", 32'(dresp_ready), 32'h1);
    chk("t1_dresp_last", 32'(dresp_last), 32'h1);
    chk("t1_dresp_data", dresp_data, 32'hDEADBEEF);
    chk("t1_iresp_ready", 32'(iresp_ready), 32'h0);
    cyc(); no_beat();
    @(negedge clk);
    chk("t1_busy_done", 32'(busy), 32'h0);
    $display("test1 single D read done");
    cyc();

    // 2: contested single-beat bursts -> D,D,D,D,I,D,D,D,D,I
    ireq_valid = 1; ireq_addr = 32'h100; ireq_len = 0;
    dreq_valid = 1; dreq_addr = 32'h200; dreq_len = 0;
    for (int k = 0; k < 10; k++) begin
      wait_busy("t2");
      beat(1'b1, 32'(k));
      @(negedge clk);
      chk($sformatf("t2_grant%0d", k), creq_addr, (k % 5 == 4) ? 32'h100 : 32'h200);
      cyc(); no_beat();
    end
    ireq_valid = 0; dreq_valid = 0;
    $display("test2 starvation sequence done");
    cyc();

    // 3: I burst of 4 beats, clean
    ireq_valid = 1; ireq_addr = 32'h300; ireq_len = 3;
    cyc();
    ireq_valid = 0;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin no_beat(); cyc(); end
      beat(b == 3, 32'(b + 1));
      @(negedge clk);
      chk($sformatf("t3_iready%0d", b), 32'(iresp_ready), 32'h1);
      chk($sformatf("t3_ilast%0d", b), 32'(iresp_last), (b == 3) ? 32'h1 : 32'h0);
      cyc();
    end
    no_beat();
    @(negedge clk);
    chk("t3_proto_err", 32'(proto_err), 32'h0);
    chk("t3_busy", 32'(busy), 32'h0);
    $display("test3 I burst done");
    cyc();

    // 4: D burst len=3 but bus ends after 2 beats
    dreq_valid = 1; dreq_addr = 32'h400; dreq_len = 3;
    cyc();
    dreq_valid = 0;
    beat(1'b0, 32'h11); cyc();
    beat(1'b1, 32'h22); cyc();
    no_beat();
    @(negedge clk);
    chk("t4_busy", 32'(busy), 32'h0);
    chk("t4_proto_err", 32'(proto_err), 32'h1);
    #1;
    dreq_valid = 1; dreq_len = 0;
    cyc();
    dreq_valid = 0;
    beat(1'b1, 32'h33); cyc(); no_beat();
    @(negedge clk);
    chk("t4_err_sticky", 32'(proto_err), 32'h1);
    $display("test4 short burst done");
    cyc();

    // 5: reset mid-burst
    ireq_valid = 1; ireq_addr = 32'h500; ireq_len = 3;
    cyc();
    ireq_valid = 0;
    beat(1'b0, 32'h1); cyc();
    beat(1'b0, 32'h2); cyc();
    resetn = 0; beat(1'b0, 32'h3);
    cyc();
    resetn = 1;
    @(negedge clk);
    chk("t5_creq_valid", 32'(creq_valid), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_proto_err", 32'(proto_err), 32'h0);
    chk("t5_iresp_ready", 32'(iresp_ready), 32'h0);
    cyc();
    beat(1'b1, 32'h4);
    @(negedge clk);
    chk("t5_stale_beat", 32'(iresp_ready), 32'h0);
    cyc(); no_beat();
    dreq_valid = 1; dreq_addr = 32'h600; dreq_len = 0;
    cyc();
    dreq_valid = 0;
    @(negedge clk);
    chk("t5_regrant", 32'(busy), 32'h1);
    #1;
    beat(1'b1, 32'h5); cyc(); no_beat();
    $display("test5 reset mid-burst done");
    cyc();

    // 6: D write field passthrough
    dreq_valid = 1; dreq_is_write = 1; dreq_strobe = 4'h3;
    dreq_data = 32'h0000ABCD; dreq_addr = 32'h2002; dreq_size = 3'd1; dreq_len = 0;
    cyc();
    dreq_valid = 0;
    cyc();
    @(negedge clk);
    chk("t6_addr", creq_addr, 32'h2002);
    chk("t6_write", 32'(creq_is_write), 32'h1);
    chk("t6_strobe", 32'(creq_strobe), 32'h3);
    chk("t6_data", creq_data, 32'h0000ABCD);
    #1;
    beat(1'b1, 32'h0); cyc(); no_beat();
    @(negedge clk);
    chk("t6_addr_clr", creq_addr, 32'h0);
    chk("t6_data_clr", creq_data, 32'h0);
    chk("t6_strobe_clr", 32'(creq_strobe), 32'h0);
    $display("test6 D write done");
    #1;
    dreq_is_write = 0; dreq_strobe = 0; dreq_data = 0;
    cyc();

    // 7: randomized traffic; the owner holds its request stable
    for (int c = 0; c < 3000; c++) begin
      resetn = ($urandom_range(0, 199) != 0);
      if (!(m_busy && !m_side)) begin
        ireq_valid = $urandom_range(0, 1); ireq_addr = $urandom;
        ireq_size = 3'($urandom_range(0, 7)); ireq_len = 4'($urandom_range(0, 3));
        ireq_is_write = ($urandom_range(0, 7) == 0); ireq_strobe = 4'($urandom);
        ireq_data = $urandom;
      end
      if (!(m_busy && m_side)) begin
        dreq_valid = $urandom_range(0, 1); dreq_addr = $urandom;
        dreq_size = 3'($urandom_range(0, 7)); dreq_len = 4'($urandom_range(0, 3));
        dreq_is_write = $urandom_range(0, 1); dreq_strobe = 4'($urandom);
        dreq_data = $urandom;
      end
      cresp_ready = $urandom_range(0, 1);
      cresp_data = $urandom;
      if (m_busy) begin
        automatic bit at_end = (m_beats == (m_side ? int'(dreq_len) : int'(ireq_len)));
        cresp_last = ($urandom_range(0, 19) == 0) ? !at_end : at_end;
      end else begin
        cresp_last = $urandom_range(0, 1);
      end
      cyc();
    end
    $display("test7 random traffic done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
